// File: rtl/fsm_seq_arbiter.sv
// Round-robin sequencer: accepts a frame from one of two requesters, clears the shared
// serial Mealy detector, shifts the frame through it MSB-first and returns the captured outputs.
module fsm_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_reset_b,
    output logic             det_in,
    input  logic             det_out,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_data,
    output logic             result_id,
    input  logic             result_ready,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             grant_any;
    logic             grant_id;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid/data until ready; ready is offered only in IDLE and only to the
    // granted side. result_valid stays high with stable data until result_ready is seen.
    always_comb begin
        next_state = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                grant_any = req0_valid | req1_valid;
                if (req0_valid && req1_valid) begin
                    grant_id = ~last_grant;
                end else begin
                    grant_id = req1_valid;
                end
                req0_ready = grant_any & ~grant_id;
                req1_ready = grant_any & grant_id;
                if (grant_any) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: next_state = SHIFT;
            SHIFT: begin
                if (bit_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The detector only sees real data in SHIFT; everywhere else it is fed zeros.
    assign det_in       = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
    assign result_valid = (state == DONE);
    assign dbg_state    = state;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            det_reset_b <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            result_data <= '0;
            result_id   <= 1'b0;
        end else begin
            state <= next_state;
            // Registered so the detector reset is low for exactly the CLEAR cycle.
            det_reset_b <= (next_state != CLEAR);
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        shift_reg   <= grant_id ? req1_data : req0_data;
                        result_id   <= grant_id;
                        result_data <= '0;
                    end
                end
                CLEAR: begin
                    bit_cnt <= CW'(WIDTH - 1);
                end
                SHIFT: begin
                    result_data[bit_cnt] <= det_out;
                    shift_reg            <= {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt              <= bit_cnt - 1'b1;
                end
                DONE: begin
                    if (result_ready) begin
                        last_grant <= result_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// Bench for fsm_seq_arbiter: directed test-plan frames followed by randomized frames,
// with a behavioural detector model and an expected-result queue.
module tb_fsm_seq_arbiter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_b;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         det_reset_b;
    logic         det_in;
    logic         det_out;
    logic         result_valid;
    logic [W-1:0] result_data;
    logic         result_id;
    logic         result_ready;
    logic [1:0]   dbg_state;

    int           errors = 0;
    int           checks = 0;
    logic         last_served;
    logic [W:0]   exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    fsm_seq_arbiter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_b      (reset_b),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .det_reset_b  (det_reset_b),
        .det_in       (det_in),
        .det_out      (det_out),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_id    (result_id),
        .result_ready (result_ready),
        .dbg_state    (dbg_state)
    );

    // ---------------- shared In/Out detector model ----------------
    // Returns {out, next_state}.
    function automatic logic [2:0] det_step(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    det_step = b ? {1'b0, 2'd1} : {1'b1, 2'd0};
            2'd1:    det_step = b ? {1'b1, 2'd1} : {1'b0, 2'd2};
            2'd2:    det_step = b ? {1'b1, 2'd3} : {1'b1, 2'd0};
            default: det_step = b ? {1'b0, 2'd1} : {1'b1, 2'd3};
        endcase
    endfunction

    logic [1:0] det_q;
    logic [2:0] det_nx;
    assign det_nx  = det_step(det_q, det_in);
    assign det_out = det_nx[2];

    always @(posedge clock or negedge det_reset_b) begin
        if (!det_reset_b) det_q <= 2'd0;
        else              det_q <= det_nx[1:0];
    end

    // Expected result: detector outputs for a frame fed MSB-first from a fresh reset.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] frame);
        logic [1:0]   s;
        logic [2:0]   r;
        logic [W-1:0] res;
        s = 2'd0;
        res = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = det_step(s, frame[i]);
            res[i] = r[2];
            s = r[1:0];
        end
        return res;
    endfunction

    // ---------------- checker / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_b      = 1'b0;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        req0_data    = '0;
        req1_data    = '0;
        result_ready = 1'b1;
        step();
        step();
        check("rst:result_valid", result_valid, 0);
        check("rst:result_data", result_data, 0);
        check("rst:result_id", result_id, 0);
        check("rst:det_reset_b", det_reset_b, 0);
        check("rst:det_in", det_in, 0);
        check("rst:readies", {req1_ready, req0_ready}, 0);
        reset_b = 1'b1;
        last_served = 1'b1;
        step();
        check("rst:det_reset_b_rise", det_reset_b, 1);
        check("rst:idle_no_valid", result_valid, 0);
    endtask

    // Called in IDLE with requester inputs already set. exp_lit < 0 means no literal check.
    task automatic run_frame(input string tag, input int exp_lit, input int stall,
                             input bit drop_after, input bit poke_req1);
        logic         exp_id;
        logic [W-1:0] frame;
        logic [W:0]   exp_e;
        #1;
        exp_id = (req0_valid && req1_valid) ? ~last_served : req1_valid;
        frame  = exp_id ? req1_data : req0_data;
        check({tag, ":ready0"}, req0_ready, !exp_id);
        check({tag, ":ready1"}, req1_ready, exp_id);
        exp_q.push_back({exp_id, ref_result(frame)});
        step();
        if (drop_after) begin
            if (exp_id) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        #1;
        check({tag, ":clear_det_reset_b"}, det_reset_b, 0);
        check({tag, ":clear_det_in"}, det_in, 0);
        for (int i = 0; i < W; i++) begin
            step();
            if (poke_req1 && i == 2) req1_valid = 1'b1;
            if (poke_req1 && i == 3) req1_valid = 1'b0;
            #1;
            check({tag, ":shift_det_reset_b"}, det_reset_b, 1);
            check({tag, ":shift_det_in"}, det_in, frame[W-1-i]);
            check({tag, ":shift_busy"}, {result_valid, req1_ready, req0_ready}, 0);
        end
        result_ready = (stall == 0);
        step();
        exp_e = exp_q.pop_front();
        check({tag, ":result_valid"}, result_valid, 1);
        check({tag, ":result_data"}, result_data, exp_e[W-1:0]);
        check({tag, ":result_id"}, result_id, exp_e[W]);
        if (exp_lit >= 0) check({tag, ":result_lit"}, result_data, exp_lit);
        for (int k = 0; k < stall; k++) begin
            step();
            check({tag, ":stall_valid"}, result_valid, 1);
            check({tag, ":stall_data"}, {result_id, result_data}, exp_e);
            check({tag, ":stall_readies"}, {req1_ready, req0_ready}, 0);
        end
        result_ready = 1'b1;
        step();
        last_served = exp_id;
        check({tag, ":after_handshake"}, result_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // single frame from requester 0
        req0_data = 8'hA5; req0_valid = 1'b1;
        run_frame("single_a5", 'h39, 0, 1, 0);

        // two frames from requester 1
        req1_data = 8'h00; req1_valid = 1'b1;
        run_frame("r1_00", 'hFF, 0, 1, 0);
        req1_data = 8'hFF; req1_valid = 1'b1;
        run_frame("r1_ff", 'h7F, 0, 1, 0);

        // both continuously valid: alternation 0,1,0,1 at full throughput
        req0_data = 8'hA5; req1_data = 8'h00;
        req0_valid = 1'b1; req1_valid = 1'b1;
        run_frame("rr0", 'h39, 0, 0, 0);
        check("rr0:id", last_served, 0);
        run_frame("rr1", 'hFF, 0, 0, 0);
        check("rr1:id", last_served, 1);
        run_frame("rr2", 'h39, 0, 0, 0);
        run_frame("rr3", 'hFF, 0, 0, 0);

        // backpressure with the other requester waiting
        run_frame("bp", 'h39, 5, 1, 0);
        run_frame("bp_next", 'hFF, 0, 1, 0);

        // withdrawn request during SHIFT, then normal grants
        req0_data = 8'hA5; req0_valid = 1'b1;
        run_frame("wd", 'h39, 0, 1, 1);
        req0_valid = 1'b1;
        run_frame("wd_next", 'h39, 0, 1, 0);
        req0_valid = 1'b1; req1_data = 8'h00; req1_valid = 1'b1;
        run_frame("wd_both", 'hFF, 0, 1, 0);
        req0_valid = 1'b0;

        // asynchronous reset in the middle of SHIFT
        req0_data = 8'hFF; req0_valid = 1'b1;
        #1;
        check("mid:ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid:pre_busy", det_reset_b, 1);
        reset_b = 1'b0;
        #1;
        check("mid:result_valid", result_valid, 0);
        check("mid:result_data", result_data, 0);
        check("mid:result_id", result_id, 0);
        check("mid:det_reset_b", det_reset_b, 0);
        check("mid:det_in", det_in, 0);
        check("mid:readies", {req1_ready, req0_ready}, 0);
        step();
        reset_b = 1'b1;
        last_served = 1'b1;
        step();
        check("mid:det_reset_b_rise", det_reset_b, 1);
        check("mid:no_result", result_valid, 0);
        req0_data = 8'hA5; req0_valid = 1'b1;
        run_frame("mid_fresh", 'h39, 0, 1, 0);

        // randomized frames
        for (int n = 0; n < 16; n++) begin
            int v;
            v = $urandom_range(1, 3);
            req0_valid = v[0];
            req1_valid = v[1];
            req0_data  = W'($urandom);
            req1_data  = W'($urandom);
            run_frame($sformatf("rnd%0d", n), -1, $urandom_range(0, 3), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_seq_arbiter.md
Name: fsm_seq_arbiter

Overview:
Two-requester round-robin sequencer that shares one serial Mealy detector, the team's 4-state "In/Out" pattern FSM.
- Accepts a parallel WIDTH-bit word from the granted requester.
- Resets the detector and shifts the word into it MSB-first, one bit per clock.
- Captures the detector's per-bit Mealy output into a WIDTH-bit result word.
- Returns the result with the requester ID over a valid/ready handshake.

Parameters:
WIDTH, 8, bits per frame shifted into the detector (legal range 2..32).

Ports:
clock  input  1  system clock, rising edge
reset_b  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a frame
req0_data  input  WIDTH  requester 0 frame, MSB shifted first
req0_ready  output  1  frame accepted from requester 0 this cycle
req1_valid  input  1  requester 1 has a frame
req1_data  input  WIDTH  requester 1 frame
req1_ready  output  1  frame accepted from requester 1 this cycle
det_reset_b  output  1  active-low reset to shared detector, registered
det_in  output  1  serial bit to detector In
det_out  input  1  detector Out (combinational Mealy output)
result_valid  output  1  result word available
result_data  output  WIDTH  captured detector outputs, MSB = first bit
result_id  output  1  requester that owns result_data
result_ready  input  1  consumer accepts result

Behaviour:
- One clock, clock; reset_b is asynchronous active-low.
- Reset values:
  - state=IDLE, last_grant=1 (req0 wins first), det_reset_b=0, det_in=0.
  - result_valid=0, result_data=0, result_id=0, both ready=0.
  - det_reset_b rises to 1 on the first clock edge after reset_b deasserts.
- States IDLE, CLEAR, SHIFT, DONE, 2-bit encoding; unused codes go to IDLE.
- IDLE:
  - Grant is combinational. If only one valid, grant it. If both valid, grant the one != last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE.
  - Transfer occurs when valid&ready. Latch data into the shift register, id into result_id, clear result_data, go to CLEAR.
  - No valid: stay in IDLE, det_reset_b=1, det_in=0.
- CLEAR (exactly 1 cycle): det_reset_b=0 for this cycle. Load bit counter with WIDTH-1. Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - det_in = shift-register MSB.
  - Each edge: result_data[cnt] <= det_out (sampled in the same cycle its bit is driven), shift left, cnt--.
  - At cnt==0 go to DONE.
  - det_reset_b=1.
- DONE:
  - result_valid=1; result_data/result_id held stable.
  - On result_ready=1: last_grant <= result_id, go to IDLE. No new grant in the same cycle.
- Latency: accept edge T. CLEAR during cycle T+1. Bits during T+2..T+WIDTH+1. result_valid from T+WIDTH+2.
- Throughput: one frame per WIDTH+3 cycles minimum, with result_ready held high.
- Requests arriving outside IDLE are ignored (ready=0). Requesters must hold valid/data until ready.
- A requester dropping valid before ready: no grant is recorded, last_grant is unchanged.
- The detector sees det_in only in SHIFT, so stale detector state never leaks into a result because of CLEAR.
- Async reset mid-SHIFT or DONE: immediate return to reset values. The frame is lost; no partial result_valid.

Test Plan:
- Single frame, WIDTH=8, req0_data=8'hA5, result_ready=1 → result_valid at T+10 with result_data=8'h39, result_id=0; det_reset_b low exactly in cycle T+1.
- Frames 8'h00 then 8'hFF from req1 → results 8'hFF then 8'h7F, result_id=1 both; the second grant follows the first result handshake.
- Both requesters continuously valid (req0=8'hA5, req1=8'h00) over 4 frames → grant order 0,1,0,1; results 39,FF,39,FF with ids 0,1,0,1.
- Backpressure: result_ready=0 for 5 cycles in DONE → result_valid and result_data stable. Both ready low; no new grant until the handshake, then IDLE next cycle.
- reset_b pulsed low during SHIFT bit 4 → all outputs at reset values immediately. After release, a fresh 8'hA5 frame still yields 8'h39.
- Grant withdrawal: req1_valid high one cycle while state=SHIFT, then low → never granted, last_grant unchanged, next lone req0 frame granted normally.
